// File: rtl/led_fade_driver_pkg.sv
// Shared defaults and channel state encoding for the LED fade driver.
// Imported by the interface, the channel and the top.
package led_fade_driver_pkg;

    localparam int PWM_BITS_DEF = 8;
    localparam int FADE_DIV_DEF = 19531;
    localparam int BRI_BITS     = 4;

    typedef enum logic [1:0] {
        CH_OFF  = 2'd0,
        CH_UP   = 2'd1,
        CH_ON   = 2'd2,
        CH_DOWN = 2'd3
    } ch_state_e;

endpackage

// File: rtl/led_fade_driver_if.sv
// Pattern/brightness sink and LED drive bundle of the fade driver.
// The master is the pattern source side, the slave is the driver.
interface led_fade_driver_if
    import led_fade_driver_pkg::*;
#(
    parameter int NUM_LEDS = 4
);

    logic [NUM_LEDS-1:0] led_in;
    logic [BRI_BITS-1:0] brightness;
    logic [NUM_LEDS-1:0] led_out;
    logic                fade_busy;

    modport master (
        output led_in,
        output brightness,
        input  led_out,
        input  fade_busy
    );

    modport slave (
        input  led_in,
        input  brightness,
        output led_out,
        output fade_busy
    );

endinterface

// File: rtl/led_fade_channel.sv
// One LED channel: fading level register, ramp state and PWM compare.
// The level walks toward its target by at most STEP per fade tick.
module led_fade_channel
    import led_fade_driver_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int STEP     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fade_tick,
    input  logic [PWM_BITS-1:0] target,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_out,
    output logic                busy
);

    localparam int            W      = PWM_BITS + 1;
    localparam logic [W-1:0]  STEP_W = W'(STEP);

    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] level_d;
    ch_state_e           state_q;
    ch_state_e           state_d;
    logic                led_out_q;
    logic                led_out_d;

    logic [W-1:0] lvl_x;
    logic [W-1:0] tgt_x;
    logic [W-1:0] diff;
    logic [W-1:0] delta;

    // One extra bit keeps the step math free of wrap; delta never
    // exceeds the remaining distance, so the level lands on target.
    always_comb begin
        lvl_x   = {1'b0, level_q};
        tgt_x   = {1'b0, target};
        diff    = (tgt_x >= lvl_x) ? (tgt_x - lvl_x) : (lvl_x - tgt_x);
        delta   = (diff < STEP_W) ? diff : STEP_W;
        level_d = level_q;
        if (fade_tick) begin
            if (tgt_x > lvl_x) begin
                level_d = PWM_BITS'(lvl_x + delta);
            end else begin
                level_d = PWM_BITS'(lvl_x - delta);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            (level_q == target) && (level_q == '0): state_d = CH_OFF;
            (level_q == target) && (level_q != '0): state_d = CH_ON;
            (level_q <  target):                    state_d = CH_UP;
            (level_q >  target):                    state_d = CH_DOWN;
        endcase
    end

    // A channel at rest in OFF is held dark outright.
    always_comb begin
        led_out_d = (state_q != CH_OFF) && (level_q > pwm_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= '0;
            state_q   <= CH_OFF;
            led_out_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            state_q   <= state_d;
            led_out_q <= led_out_d;
        end
    end

    assign led_out = led_out_q;
    assign busy    = (level_q != target);

endmodule

// File: rtl/led_fade_driver.sv
// LED fade driver top: input register, fade prescaler, shared PWM
// counter, brightness expansion and the per-channel fade engines.
module led_fade_driver
    import led_fade_driver_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int FADE_DIV = FADE_DIV_DEF,
    parameter int STEP     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    led_fade_driver_if.slave bus
);

    localparam int               PRE_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FADE_DIV - 1);

    logic [NUM_LEDS-1:0] in_q;
    logic [NUM_LEDS-1:0] in_d;
    logic [BRI_BITS-1:0] bri_q;
    logic [BRI_BITS-1:0] bri_d;
    logic [PRE_W-1:0]    pre_q;
    logic [PRE_W-1:0]    pre_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic                fade_busy_q;
    logic                fade_busy_d;

    logic                fade_tick;
    logic [PWM_BITS-1:0] full_level;
    logic [NUM_LEDS-1:0] ch_busy;
    logic [NUM_LEDS-1:0] ch_led;

    // Pattern and brightness share one register stage so a change on
    // both in the same cycle yields a single new target.
    always_comb begin
        in_d        = bus.led_in;
        bri_d       = bus.brightness;
        fade_tick   = (pre_q == PRE_LAST);
        pre_d       = fade_tick ? '0 : pre_q + 1'b1;
        pwm_cnt_d   = pwm_cnt_q + 1'b1;
        fade_busy_d = |ch_busy;
    end

    // Brightness is MSB-aligned and repeated down into the low bits.
    for (genvar k = 0; k < PWM_BITS; k++) begin : g_exp
        assign full_level[PWM_BITS-1-k] = bri_q[BRI_BITS-1-(k % BRI_BITS)];
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        logic [PWM_BITS-1:0] target;

        assign target = in_q[i] ? full_level : '0;

        led_fade_channel #(
            .PWM_BITS (PWM_BITS),
            .STEP     (STEP)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .fade_tick (fade_tick),
            .target    (target),
            .pwm_cnt   (pwm_cnt_q),
            .led_out   (ch_led[i]),
            .busy      (ch_busy[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q        <= '0;
            bri_q       <= '0;
            pre_q       <= '0;
            pwm_cnt_q   <= '0;
            fade_busy_q <= 1'b0;
        end else begin
            in_q        <= in_d;
            bri_q       <= bri_d;
            pre_q       <= pre_d;
            pwm_cnt_q   <= pwm_cnt_d;
            fade_busy_q <= fade_busy_d;
        end
    end

    assign bus.led_out   = ch_led;
    assign bus.fade_busy = fade_busy_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver: directed ramps plus random pattern and
// brightness traffic, checked every cycle against a cycle-count model.
module tb_led_fade_driver;

    localparam int N      = 4;
    localparam int PB     = 4;
    localparam int FD     = 4;
    localparam int ST     = 1;
    localparam int PERIOD = 1 << PB;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_asrt = 0;
    int   n_fail = 0;

    led_fade_driver_if #(.NUM_LEDS(N)) bus ();

    led_fade_driver #(
        .NUM_LEDS (N),
        .PWM_BITS (PB),
        .FADE_DIV (FD),
        .STEP     (ST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [PB-1:0] dut_lvl [N];
    logic [1:0]    dut_st  [N];

    for (genvar g = 0; g < N; g++) begin : g_tap
        assign dut_lvl[g] = dut.g_ch[g].u_ch.level_q;
        assign dut_st[g]  = dut.g_ch[g].u_ch.state_q;
    end

    // Model: after n clocks since reset the prescaler sits at n%FD and
    // the PWM counter at n%PERIOD; levels chase targets on each tick.
    int           m_lvl [N] = '{default: 0};
    logic [N-1:0] m_in   = '0;
    logic [3:0]   m_bri  = '0;
    int           m_n    = 0;
    logic [N-1:0] m_led  = '0;
    logic         m_busy = 1'b0;

    function automatic int full_of(logic [3:0] b);
        return int'(b) * (PERIOD - 1) / 15;
    endfunction

    function automatic int tgt_of(int i);
        return m_in[i] ? full_of(m_bri) : 0;
    endfunction

    function automatic int approach(int lvl, int tgt);
        if (lvl < tgt) return (tgt - lvl < ST) ? tgt : lvl + ST;
        if (lvl > tgt) return (lvl - tgt < ST) ? tgt : lvl - ST;
        return lvl;
    endfunction

    function automatic logic model_busy();
        for (int i = 0; i < N; i++)
            if (m_lvl[i] != tgt_of(i)) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_lvl[i] <= 0;
            m_in   <= '0;
            m_bri  <= '0;
            m_n    <= 0;
            m_led  <= '0;
            m_busy <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                m_led[i] <= (m_lvl[i] > (m_n % PERIOD));
                if (m_n % FD == FD - 1)
                    m_lvl[i] <= approach(m_lvl[i], tgt_of(i));
            end
            m_busy <= model_busy();
            m_in   <= bus.led_in;
            m_bri  <= bus.brightness;
            m_n    <= m_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s lvl%0d", tag, i), 32'(dut_lvl[i]), m_lvl[i]);
        chk({tag, " led_out"}, 32'(bus.led_out), 32'(m_led));
        chk({tag, " busy"}, 32'(bus.fade_busy), 32'(m_busy));
    endtask

    function automatic bit all_at(int v);
        for (int i = 0; i < N; i++)
            if (int'(dut_lvl[i]) != v) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        int cnt;
        int hi;
        bus.led_in     = '0;
        bus.brightness = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset led_out", 32'(bus.led_out), 0);
        chk("reset busy", 32'(bus.fade_busy), 0);
        rst_n = 1'b1;
        repeat (4) step("idle");

        // ramp up on ch0
        bus.brightness = 4'd15;
        bus.led_in     = 4'b0001;
        cnt = 0;
        while (dut_lvl[0] != 4'd15 && cnt < 200) begin step("up"); cnt++; end
        chk("up reached", 32'(dut_lvl[0]), 15);
        chk("up time 58..61", 32'(cnt >= 58 && cnt <= 61), 1);
        step("up settle");
        chk("up busy low", 32'(bus.fade_busy), 0);
        chk("up state ON", 32'(dut_st[0]), 2);
        hi = 0;
        repeat (16) begin step("duty15"); hi += int'(bus.led_out[0]); end
        chk("duty 15/16", hi, 15);

        // ramp down
        bus.led_in = 4'b0000;
        cnt = 0;
        while (dut_lvl[0] != 4'd0 && cnt < 200) begin step("down"); cnt++; end
        chk("down reached", 32'(dut_lvl[0]), 0);
        chk("down time 58..61", 32'(cnt >= 58 && cnt <= 61), 1);
        step("down settle");
        chk("down state OFF", 32'(dut_st[0]), 0);
        hi = 0;
        repeat (20) begin step("dark"); hi += int'(bus.led_out[0]); end
        chk("down led stays 0", hi, 0);

        // reversal mid-ramp
        bus.led_in = 4'b0001;
        cnt = 0;
        while (dut_lvl[0] != 4'd7 && cnt < 100) begin step("rev up"); cnt++; end
        chk("rev at 7", 32'(dut_lvl[0]), 7);
        bus.led_in = 4'b0000;
        cnt = 0;
        while (dut_lvl[0] == 4'd7 && cnt < 10) begin step("rev"); cnt++; end
        chk("rev no jump", 32'(dut_lvl[0]), 6);
        chk("rev next tick", cnt, 4);
        cnt = 0;
        while (dut_lvl[0] != 4'd0 && cnt < 100) begin step("rev down"); cnt++; end
        chk("rev reaches 0", 32'(dut_lvl[0]), 0);

        // global brightness
        bus.led_in = 4'b1111;
        cnt = 0;
        while (!(all_at(15) && !bus.fade_busy) && cnt < 200) begin step("all up"); cnt++; end
        chk("all at 15", 32'(all_at(15)), 1);
        bus.brightness = 4'd8;
        cnt = 0;
        while (!(all_at(8) && !bus.fade_busy) && cnt < 200) begin step("dim"); cnt++; end
        chk("all at 8", 32'(all_at(8)), 1);
        chk("dim busy low", 32'(bus.fade_busy), 0);
        for (int i = 0; i < N; i++) chk($sformatf("dim state ON %0d", i), 32'(dut_st[i]), 2);
        hi = 0;
        repeat (16) begin step("duty8"); hi += int'(bus.led_out[2]); end
        chk("duty 8/16", hi, 8);
        bus.brightness = 4'd0;
        cnt = 0;
        while (!(all_at(0) && !bus.fade_busy) && cnt < 200) begin step("bri0"); cnt++; end
        chk("all at 0", 32'(all_at(0)), 1);
        step("bri0 settle");
        chk("bri0 state OFF", 32'(dut_st[1]), 0);
        hi = 0;
        repeat (16) begin step("bri0 dark"); hi += int'(bus.led_out != '0); end
        chk("bri0 led_out 0", hi, 0);

        // reset in the middle of a ramp
        bus.led_in     = 4'b1111;
        bus.brightness = 4'd15;
        repeat (30) step("pre rst");
        chk("pre rst busy", 32'(bus.fade_busy), 1);
        chk("pre rst lvl>0", 32'(dut_lvl[0] != 0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async led_out", 32'(bus.led_out), 0);
        chk("async busy", 32'(bus.fade_busy), 0);
        for (int i = 0; i < N; i++) chk($sformatf("async lvl%0d", i), 32'(dut_lvl[i]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step("post rst");

        // counter-driven pattern with random brightness
        for (int v = 0; v < 32; v++) begin
            bus.led_in = 4'(v);
            if (v % 4 == 0) bus.brightness = 4'($urandom_range(1, 15));
            repeat (40) step("count");
        end

        // random traffic
        repeat (400) begin
            if ($urandom_range(0, 7) == 0) bus.led_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0) bus.brightness = 4'($urandom);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
